// File: rtl/stopwatch_display.sv
// Multiplexed 4-digit common-anode 7-segment driver for the stopwatch MM:SS.
// Ports: clk, reset_n (async low); seconds/minutes/run in; seg/an/dp out (active-low).
module stopwatch_display #(
    parameter int SCAN_DIV     = 1000,
    parameter int BLINK_FRAMES = 32
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] seconds,
    input  logic [5:0] minutes,
    input  logic       run,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int FW = $clog2(BLINK_FRAMES + 1);
    localparam logic [DW-1:0] DIV_MAX = DW'(SCAN_DIV - 1);
    localparam logic [FW-1:0] FR_MAX = FW'(BLINK_FRAMES - 1);
    localparam logic [6:0] DASH = 7'b0111111;

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    logic [DW-1:0] div_cnt;
    logic [1:0]    dig;
    logic          wrap;
    logic          boundary;

    state_t      state;
    logic [2:0]  cnt;
    logic [5:0]  cap_sec;
    logic [5:0]  cap_min;
    logic        cap_run;
    logic [13:0] sr_s;
    logic [13:0] sr_m;

    logic [7:0] sh_s;
    logic [7:0] sh_m;
    logic       sh_s_bad;
    logic       sh_m_bad;
    logic       sh_run;

    logic [7:0] disp_s;
    logic [7:0] disp_m;
    logic       disp_s_bad;
    logic       disp_m_bad;
    logic       disp_run;

    logic [FW-1:0] fcnt;
    logic          phase;

    logic [3:0] nib;
    logic       bad;
    logic [6:0] code;
    logic [6:0] seg_n;
    logic [3:0] an_n;
    logic       dp_n;

    // One double-dabble iteration on {tens, ones, binary}.
    function automatic logic [13:0] dd_step(input logic [13:0] r);
        logic [13:0] a;
        a = r;
        if (a[9:6] >= 4'd5)
            a[9:6] = a[9:6] + 4'd3;
        if (a[13:10] >= 4'd5)
            a[13:10] = a[13:10] + 4'd3;
        return a << 1;
    endfunction

    assign wrap     = (div_cnt == DIV_MAX);
    assign boundary = wrap && (dig == 2'd3);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= '0;
            dig     <= 2'd0;
        end else if (wrap) begin
            div_cnt <= '0;
            dig     <= dig + 2'd1;
        end else begin
            div_cnt <= div_cnt + DW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            cnt      <= 3'd0;
            cap_sec  <= 6'd0;
            cap_min  <= 6'd0;
            cap_run  <= 1'b0;
            sr_s     <= 14'd0;
            sr_m     <= 14'd0;
            sh_s     <= 8'd0;
            sh_m     <= 8'd0;
            sh_s_bad <= 1'b0;
            sh_m_bad <= 1'b0;
            sh_run   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (boundary) begin
                        cap_sec <= seconds;
                        cap_min <= minutes;
                        cap_run <= run;
                        sr_s    <= {8'd0, seconds};
                        sr_m    <= {8'd0, minutes};
                        cnt     <= 3'd0;
                        state   <= CONV;
                    end
                end
                CONV: begin
                    sr_s <= dd_step(sr_s);
                    sr_m <= dd_step(sr_m);
                    cnt  <= cnt + 3'd1;
                    if (cnt == 3'd5)
                        state <= DONE;
                end
                DONE: begin
                    sh_s     <= sr_s[13:6];
                    sh_m     <= sr_m[13:6];
                    sh_s_bad <= (cap_sec >= 6'd60);
                    sh_m_bad <= (cap_min >= 6'd60);
                    sh_run   <= cap_run;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            disp_s     <= 8'd0;
            disp_m     <= 8'd0;
            disp_s_bad <= 1'b0;
            disp_m_bad <= 1'b0;
            disp_run   <= 1'b0;
        end else if (boundary) begin
            disp_s     <= sh_s;
            disp_m     <= sh_m;
            disp_s_bad <= sh_s_bad;
            disp_m_bad <= sh_m_bad;
            disp_run   <= sh_run;
        end
    end

    // Colon: steady while stopped, toggles every BLINK_FRAMES frames while running.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fcnt  <= '0;
            phase <= 1'b1;
        end else if (!disp_run) begin
            fcnt  <= '0;
            phase <= 1'b1;
        end else if (boundary) begin
            if (fcnt == FR_MAX) begin
                fcnt  <= '0;
                phase <= ~phase;
            end else begin
                fcnt <= fcnt + FW'(1);
            end
        end
    end

    always_comb begin
        nib = 4'd0;
        bad = 1'b0;
        unique case (dig)
            2'd0: begin nib = disp_s[3:0]; bad = disp_s_bad; end
            2'd1: begin nib = disp_s[7:4]; bad = disp_s_bad; end
            2'd2: begin nib = disp_m[3:0]; bad = disp_m_bad; end
            2'd3: begin nib = disp_m[7:4]; bad = disp_m_bad; end
            default: ;
        endcase
    end

    always_comb begin
        code = 7'b1111111;
        case (nib)
            4'd0: code = 7'b1000000;
            4'd1: code = 7'b1111001;
            4'd2: code = 7'b0100100;
            4'd3: code = 7'b0110000;
            4'd4: code = 7'b0011001;
            4'd5: code = 7'b0010010;
            4'd6: code = 7'b0000010;
            4'd7: code = 7'b1111000;
            4'd8: code = 7'b0000000;
            4'd9: code = 7'b0010000;
            default: code = 7'b1111111;
        endcase
        seg_n = bad ? DASH : code;
        an_n  = ~(4'b0001 << dig);
        dp_n  = !((dig == 2'd2) && phase);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seg <= 7'b1111111;
            an  <= 4'b1111;
            dp  <= 1'b1;
        end else begin
            seg <= seg_n;
            an  <= an_n;
            dp  <= dp_n;
        end
    end

endmodule

// File: tb/tb_stopwatch_display.sv
// Directed bench for stopwatch_display with SCAN_DIV=4, BLINK_FRAMES=2.
// Ports of DUT all driven/observed; prints one summary line.
module tb_stopwatch_display;

    logic       clk;
    logic       reset_n;
    logic [5:0] seconds;
    logic [5:0] minutes;
    logic       run;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;

    int checks;
    int errors;

    localparam logic [6:0] D0 = 7'b1000000;
    localparam logic [6:0] D1 = 7'b1111001;
    localparam logic [6:0] D2 = 7'b0100100;
    localparam logic [6:0] D3 = 7'b0110000;
    localparam logic [6:0] D4 = 7'b0011001;
    localparam logic [6:0] D5 = 7'b0010010;
    localparam logic [6:0] D6 = 7'b0000010;
    localparam logic [6:0] D7 = 7'b1111000;
    localparam logic [6:0] D8 = 7'b0000000;
    localparam logic [6:0] D9 = 7'b0010000;
    localparam logic [6:0] DS = 7'b0111111;

    typedef struct {
        logic [5:0] sec;
        logic [5:0] min;
        logic [6:0] s0;
        logic [6:0] s1;
        logic [6:0] s2;
        logic [6:0] s3;
    } vec_t;

    vec_t tbl [8];

    stopwatch_display #(
        .SCAN_DIV(4),
        .BLINK_FRAMES(2)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .seconds(seconds),
        .minutes(minutes),
        .run(run),
        .seg(seg),
        .an(an),
        .dp(dp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_reset(input string nm);
        checks++;
        if ({an, seg, dp} !== 12'hFFF) begin
            errors++;
            $display("FAIL %s: an/seg/dp got %b/%b/%b want 1111/1111111/1",
                     nm, an, seg, dp);
        end
    endtask

    // Samples frame cycles [from,to); each digit occupies 4 consecutive samples.
    task automatic chk_span(input string nm,
                            input logic [6:0] e0, input logic [6:0] e1,
                            input logic [6:0] e2, input logic [6:0] e3,
                            input logic dpl, input int from, input int to);
        logic [3:0] ea;
        logic [6:0] es;
        logic       ed;
        int         d;
        for (int s = from; s < to; s++) begin
            tick(1);
            d = s / 4;
            ea = 4'b1111;
            ea[d] = 1'b0;
            case (d)
                0: es = e0;
                1: es = e1;
                2: es = e2;
                default: es = e3;
            endcase
            ed = (d == 2) ? dpl : 1'b1;
            checks++;
            if ({an, seg, dp} !== {ea, es, ed}) begin
                errors++;
                $display("FAIL %s cyc %0d: an/seg/dp got %b/%b/%b want %b/%b/%b",
                         nm, s, an, seg, dp, ea, es, ed);
            end
        end
    endtask

    task automatic chk_frame(input string nm,
                             input logic [6:0] e0, input logic [6:0] e1,
                             input logic [6:0] e2, input logic [6:0] e3,
                             input logic dpl);
        chk_span(nm, e0, e1, e2, e3, dpl, 0, 16);
    endtask

    initial begin
        checks = 0;
        errors = 0;

        tbl[0] = '{sec: 6'd34, min: 6'd12, s0: D4, s1: D3, s2: D2, s3: D1};
        tbl[1] = '{sec: 6'd59, min: 6'd0,  s0: D9, s1: D5, s2: D0, s3: D0};
        tbl[2] = '{sec: 6'd63, min: 6'd5,  s0: DS, s1: DS, s2: D5, s3: D0};
        tbl[3] = '{sec: 6'd7,  min: 6'd60, s0: D7, s1: D0, s2: DS, s3: DS};
        tbl[4] = '{sec: 6'd26, min: 6'd48, s0: D6, s1: D2, s2: D8, s3: D4};
        tbl[5] = '{sec: 6'd60, min: 6'd63, s0: DS, s1: DS, s2: DS, s3: DS};
        tbl[6] = '{sec: 6'd10, min: 6'd59, s0: D0, s1: D1, s2: D9, s3: D5};
        tbl[7] = '{sec: 6'd18, min: 6'd37, s0: D8, s1: D1, s2: D7, s3: D3};

        seconds = 6'd0;
        minutes = 6'd0;
        run     = 1'b0;
        reset_n = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        chk_reset("reset_async");
        #9;
        reset_n = 1'b1;

        chk_frame("first_frame", D0, D0, D0, D0, 1'b0);

        for (int i = 0; i < 8; i++) begin
            seconds = tbl[i].sec;
            minutes = tbl[i].min;
            tick(32);
            chk_frame($sformatf("vec%0d", i),
                      tbl[i].s0, tbl[i].s1, tbl[i].s2, tbl[i].s3, 1'b0);
        end

        // Mid-frame change two cycles after a boundary.
        seconds = 6'd34;
        minutes = 6'd12;
        tick(32);
        chk_span("mid_pre", D4, D3, D2, D1, 1'b0, 0, 2);
        seconds = 6'd35;
        chk_span("mid_cur", D4, D3, D2, D1, 1'b0, 2, 16);
        chk_frame("mid_hold", D4, D3, D2, D1, 1'b0);
        chk_frame("mid_new", D5, D3, D2, D1, 1'b0);

        // Colon blink while running, then steady once stopped.
        run = 1'b1;
        tick(32);
        chk_frame("blink_a0", D5, D3, D2, D1, 1'b0);
        chk_frame("blink_a1", D5, D3, D2, D1, 1'b0);
        chk_frame("blink_b0", D5, D3, D2, D1, 1'b1);
        chk_frame("blink_b1", D5, D3, D2, D1, 1'b1);
        chk_frame("blink_c0", D5, D3, D2, D1, 1'b0);
        chk_frame("blink_c1", D5, D3, D2, D1, 1'b0);
        run = 1'b0;
        tick(32);
        chk_frame("stop_0", D5, D3, D2, D1, 1'b0);
        chk_frame("stop_1", D5, D3, D2, D1, 1'b0);

        // Reset pulse in the middle of a conversion.
        seconds = 6'd34;
        tick(3);
        reset_n = 1'b0;
        #1;
        chk_reset("reset_conv");
        tick(2);
        chk_reset("reset_hold");
        #3;
        reset_n = 1'b1;
        chk_frame("rst_f0", D0, D0, D0, D0, 1'b0);
        chk_frame("rst_f1", D0, D0, D0, D0, 1'b0);
        chk_frame("rst_f2", D4, D3, D2, D1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stopwatch_display.md
# stopwatch_display

Drives a 4-digit, common-anode, multiplexed 7-segment display from the stopwatch's `minutes`/`seconds`/`run` outputs; sits directly downstream of `stopwatch`. Each field is converted to BCD with a sequential double-dabble engine and double-buffered so a displayed frame never mixes old and new values. The middle decimal point acts as the MM:SS colon: steady while stopped, blinking while running.

## Interface
- `SCAN_DIV`, default 1000: clock cycles each digit is lit; must be ≥ 2.
- `BLINK_FRAMES`, default 32: frames per colon blink half-period while running; must be ≥ 1.

- `clk`  in  1  system clock, rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `seconds`  in  6  binary seconds from stopwatch
- `minutes`  in  6  binary minutes from stopwatch
- `run`  in  1  stopwatch running flag
- `seg`  out  7  segments {g,f,e,d,c,b,a}, active-low
- `an`  out  4  digit enables, active-low; an[0]=seconds ones, an[1]=seconds tens, an[2]=minutes ones, an[3]=minutes tens
- `dp`  out  1  decimal point/colon, active-low; lit only in the an[2] slot

## Operation
- Scan: `div_cnt` counts 0..SCAN_DIV-1. On wrap, digit index `dig` (0..3) increments mod 4.
- Frame boundary: the cycle in which `div_cnt` wraps with `dig`==3. One frame is 4*SCAN_DIV cycles.
- Conversion FSM, states IDLE, CONV, DONE:
  - IDLE → CONV at a frame boundary. Capture `seconds`, `minutes` and `run` into capture registers and clear the shift count.
  - CONV: run 6 double-dabble iterations, both fields in parallel, one per cycle. Add 3 to any BCD nibble ≥ 5, then shift. After the 6th iteration → DONE.
  - DONE: write both BCD results and the captured `run` to shadow registers, then → IDLE.
  - Conversion completes 7 cycles after the boundary. Shadow registers are always valid before the next boundary, because 4*SCAN_DIV ≥ 8.
- Display registers load from the shadow registers at each frame boundary, in the same cycle as the new capture. Input-to-display latency is therefore one full frame after the capturing boundary.
- Out-of-range field (value 60–63): both digits of that field show a dash (7'b0111111). The other field is unaffected. The range check is done on the captured value.
- Segment codes, active-low gfedcba:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- Colon:
  - Displayed run=0: blink phase forced on (dp lit in the an[2] slot) and frame counter cleared.
  - Displayed run=1: the frame counter counts boundaries. The phase toggles every BLINK_FRAMES boundaries, starting lit.
- No leading-zero blanking.

## Timing
- Reset, asynchronous, active while `reset_n` is low:
  - Outputs: an=4'b1111, seg=7'b1111111, dp=1.
  - Internal state: `div_cnt`=0, `dig`=0, FSM=IDLE, shadow and display registers = 00:00, run=0, colon phase on.
- `seg`/`an`/`dp` are registered from the current `dig` and display registers, so they lag `dig` by one cycle.
  - First edge after reset release: an=1110, seg=1000000.
- Each digit is held exactly SCAN_DIV cycles. Exactly one `an` bit is low outside reset.
- Reset mid-operation: takes effect immediately. Any in-progress conversion is discarded and display returns to 00:00.
- Input changes between boundaries are ignored. Only the value present at a boundary cycle is captured.

## Test plan
- Reset behaviour:
  - Stimulus: assert `reset_n`=0 between clock edges.
  - Required response: an=1111, seg=1111111, dp=1 immediately, without waiting for an edge.
  - After release: first frame shows 0,0,0,0 in order an=1110,1101,1011,0111.
- Static value (SCAN_DIV=4), stimulus minutes=12, seconds=34:
  - Frame after the capturing boundary: an=1110 seg=0011001, an=1101 seg=0110000, an=1011 seg=0100100 dp=0, an=0111 seg=1111001.
  - Each digit is held 4 cycles.
- Mid-frame change: seconds goes 34→35 two cycles after a boundary.
  - Display stays 12:34 through the following frame.
  - 12:35 appears exactly one frame after the next boundary.
  - No frame mixes 3/4 digits with 3/5 digits.
- Range edges:
  - seconds=59, minutes=0 → 00:59.
  - seconds=63 → dashes (0111111) in the an[0]/an[1] slots, minutes digits normal.
  - minutes=60 → dashes in the an[2]/an[3] slots.
- Colon (BLINK_FRAMES=2):
  - run=1 captured: dp low in the an[2] slot for 2 frames, then high for 2 frames, repeating.
  - run=0 captured: dp low in every frame.
  - dp is high in all other slots.
- Reset during conversion: pulse `reset_n` low 3 cycles after a boundary, with 12:34 applied.
  - Display shows 00:00 for the next frame.
  - 12:34 appears one frame after the next boundary.
